// File: rtl/reorder_buffer.sv
// Reorder buffer: circular queue that tracks in-flight instructions, renames
// destination registers to ROB ids, accepts out-of-order writebacks and
// commits results in program order. A mispredicted branch reaching the head
// flushes the whole buffer and redirects fetch.
// Optional feature: define ROB_WB_BYPASS_EN to forward a same-cycle
// writeback value to the operand lookup ports.
module reorder_buffer #(
    parameter int ROB_IDX_W = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rdy,
    input  logic                 issue_valid,
    input  logic [4:0]           issue_rd,
    input  logic                 issue_is_branch,
    input  logic [31:0]          issue_alt_pc,
    output logic                 full,
    output logic [ROB_IDX_W-1:0] issue_rob_id,
    input  logic                 wb_valid,
    input  logic [ROB_IDX_W-1:0] wb_rob_id,
    input  logic [31:0]          wb_value,
    input  logic                 wb_mispredict,
    output logic                 need_set_reg_dep,
    output logic [4:0]           set_dep_reg_id,
    output logic [ROB_IDX_W-1:0] set_dep_rob_id,
    output logic                 need_set_reg_value,
    output logic [4:0]           set_value_reg_id,
    output logic [31:0]          set_val,
    output logic [ROB_IDX_W-1:0] set_reg_rob_id,
    input  logic [ROB_IDX_W-1:0] need_rob_id1,
    input  logic [ROB_IDX_W-1:0] need_rob_id2,
    output logic                 rob_value1_ready,
    output logic                 rob_value2_ready,
    output logic [31:0]          rob_value1,
    output logic [31:0]          rob_value2,
    output logic                 clear,
    output logic [31:0]          redirect_pc
);

    localparam int DEPTH = 1 << ROB_IDX_W;
    localparam logic [ROB_IDX_W:0] DEPTH_CNT = (ROB_IDX_W + 1)'(DEPTH);
    localparam logic [ROB_IDX_W:0] ONE_CNT   = (ROB_IDX_W + 1)'(1);

    logic [ROB_IDX_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [ROB_IDX_W:0]   count_q, count_d;
    logic [DEPTH-1:0]     busy_q, busy_d, ready_q, ready_d;
    logic [DEPTH-1:0]     is_branch_q, is_branch_d, mispredict_q, mispredict_d;
    logic [4:0]           rd_q     [DEPTH];
    logic [4:0]           rd_d     [DEPTH];
    logic [31:0]          value_q  [DEPTH];
    logic [31:0]          value_d  [DEPTH];
    logic [31:0]          alt_pc_q [DEPTH];
    logic [31:0]          alt_pc_d [DEPTH];

    logic issue_accept, commit, flush, commit_write;

    // Handshake decode: issue acceptance, in-order commit and flush detection
    always_comb begin
        full         = (count_q == DEPTH_CNT);
        commit       = (count_q != '0) && ready_q[head_q] && rdy;
        flush        = commit && is_branch_q[head_q] && mispredict_q[head_q];
        commit_write = commit && !is_branch_q[head_q] && (rd_q[head_q] != 5'd0);
        issue_accept = issue_valid && !full && rdy && !flush;
    end

    // Outputs to issue, register file and fetch; all zero when idle
    always_comb begin
        issue_rob_id       = issue_valid ? tail_q : '0;
        need_set_reg_dep   = issue_accept && (issue_rd != 5'd0);
        set_dep_reg_id     = need_set_reg_dep ? issue_rd : '0;
        set_dep_rob_id     = need_set_reg_dep ? tail_q : '0;
        need_set_reg_value = commit_write;
        set_value_reg_id   = commit_write ? rd_q[head_q] : '0;
        set_val            = commit_write ? value_q[head_q] : '0;
        set_reg_rob_id     = commit_write ? head_q : '0;
        clear              = flush;
        redirect_pc        = flush ? alt_pc_q[head_q] : '0;
    end

    // Operand lookups; an entry only reports a value while it is occupied
    always_comb begin
        rob_value1_ready = busy_q[need_rob_id1] && ready_q[need_rob_id1];
        rob_value2_ready = busy_q[need_rob_id2] && ready_q[need_rob_id2];
        rob_value1       = busy_q[need_rob_id1] ? value_q[need_rob_id1] : '0;
        rob_value2       = busy_q[need_rob_id2] ? value_q[need_rob_id2] : '0;
`ifdef ROB_WB_BYPASS_EN
        if (wb_valid && (wb_rob_id == need_rob_id1) && busy_q[need_rob_id1]) begin
            rob_value1_ready = 1'b1;
            rob_value1       = wb_value;
        end
        if (wb_valid && (wb_rob_id == need_rob_id2) && busy_q[need_rob_id2]) begin
            rob_value2_ready = 1'b1;
            rob_value2       = wb_value;
        end
`endif
    end

    // Next-state: writeback, commit, issue, or full flush on misprediction
    always_comb begin
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        busy_d       = busy_q;
        ready_d      = ready_q;
        is_branch_d  = is_branch_q;
        mispredict_d = mispredict_q;
        rd_d         = rd_q;
        value_d      = value_q;
        alt_pc_d     = alt_pc_q;
        if (flush) begin
            head_d       = '0;
            tail_d       = '0;
            count_d      = '0;
            busy_d       = '0;
            ready_d      = '0;
            mispredict_d = '0;
        end else begin
            if (wb_valid && rdy && busy_q[wb_rob_id]) begin
                ready_d[wb_rob_id]      = 1'b1;
                value_d[wb_rob_id]      = wb_value;
                mispredict_d[wb_rob_id] = wb_mispredict;
            end
            if (commit) begin
                busy_d[head_q]  = 1'b0;
                ready_d[head_q] = 1'b0;
                head_d          = head_q + 1'b1;
            end
            if (issue_accept) begin
                busy_d[tail_q]       = 1'b1;
                ready_d[tail_q]      = 1'b0;
                mispredict_d[tail_q] = 1'b0;
                is_branch_d[tail_q]  = issue_is_branch;
                rd_d[tail_q]         = issue_rd;
                value_d[tail_q]      = '0;
                alt_pc_d[tail_q]     = issue_alt_pc;
                tail_d               = tail_q + 1'b1;
            end
            if (issue_accept && !commit) begin
                count_d = count_q + ONE_CNT;
            end else if (commit && !issue_accept) begin
                count_d = count_q - ONE_CNT;
            end
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            busy_q       <= '0;
            ready_q      <= '0;
            is_branch_q  <= '0;
            mispredict_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                rd_q[i]     <= '0;
                value_q[i]  <= '0;
                alt_pc_q[i] <= '0;
            end
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            busy_q       <= busy_d;
            ready_q      <= ready_d;
            is_branch_q  <= is_branch_d;
            mispredict_q <= mispredict_d;
            rd_q         <= rd_d;
            value_q      <= value_d;
            alt_pc_q     <= alt_pc_d;
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: commit/flush events expected by the
// stimulus go into a queue that a negedge monitor pops and compares.
module tb_reorder_buffer;

`ifdef ROB_WB_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, rdy;
    logic        issue_valid, issue_is_branch;
    logic [4:0]  issue_rd;
    logic [31:0] issue_alt_pc;
    logic        full;
    logic [2:0]  issue_rob_id;
    logic        wb_valid, wb_mispredict;
    logic [2:0]  wb_rob_id;
    logic [31:0] wb_value;
    logic        need_set_reg_dep;
    logic [4:0]  set_dep_reg_id;
    logic [2:0]  set_dep_rob_id;
    logic        need_set_reg_value;
    logic [4:0]  set_value_reg_id;
    logic [31:0] set_val;
    logic [2:0]  set_reg_rob_id;
    logic [2:0]  need_rob_id1, need_rob_id2;
    logic        rob_value1_ready, rob_value2_ready;
    logic [31:0] rob_value1, rob_value2;
    logic        clear;
    logic [31:0] redirect_pc;

    reorder_buffer #(.ROB_IDX_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .issue_is_branch(issue_is_branch), .issue_alt_pc(issue_alt_pc),
        .full(full), .issue_rob_id(issue_rob_id),
        .wb_valid(wb_valid), .wb_rob_id(wb_rob_id), .wb_value(wb_value),
        .wb_mispredict(wb_mispredict),
        .need_set_reg_dep(need_set_reg_dep), .set_dep_reg_id(set_dep_reg_id),
        .set_dep_rob_id(set_dep_rob_id),
        .need_set_reg_value(need_set_reg_value), .set_value_reg_id(set_value_reg_id),
        .set_val(set_val), .set_reg_rob_id(set_reg_rob_id),
        .need_rob_id1(need_rob_id1), .need_rob_id2(need_rob_id2),
        .rob_value1_ready(rob_value1_ready), .rob_value2_ready(rob_value2_ready),
        .rob_value1(rob_value1), .rob_value2(rob_value2),
        .clear(clear), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_clear;
        logic [4:0]  reg_id;
        logic [31:0] val;
        logic [2:0]  rob;
        logic [31:0] pc;
    } exp_t;

    exp_t exp_q[$];
    int   pass_cnt = 0;
    int   tot_cnt  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tot_cnt++;
        if (act !== req)
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        else
            pass_cnt++;
    endtask

    task automatic push_commit(input logic [4:0] r, input logic [31:0] v, input logic [2:0] id);
        exp_t e;
        e.is_clear = 1'b0; e.reg_id = r; e.val = v; e.rob = id; e.pc = '0;
        exp_q.push_back(e);
    endtask

    task automatic push_clear(input logic [31:0] pc);
        exp_t e;
        e.is_clear = 1'b1; e.reg_id = '0; e.val = '0; e.rob = '0; e.pc = pc;
        exp_q.push_back(e);
    endtask

    // Monitor: every commit or flush pulse must match the next expected event
    always @(negedge clk) begin
        if (need_set_reg_value || clear) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_commit", {need_set_reg_value, clear}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.is_clear) begin
                    chk("flush_clear", clear, 32'd1);
                    chk("flush_no_regwrite", need_set_reg_value, 32'd0);
                    chk("flush_redirect_pc", redirect_pc, e.pc);
                end else begin
                    chk("commit_no_clear", clear, 32'd0);
                    chk("commit_reg_id", set_value_reg_id, e.reg_id);
                    chk("commit_val", set_val, e.val);
                    chk("commit_rob_id", set_reg_rob_id, e.rob);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        issue_valid = 0; issue_rd = 0; issue_is_branch = 0; issue_alt_pc = 0;
        wb_valid = 0; wb_rob_id = 0; wb_value = 0; wb_mispredict = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0; rdy = 1; need_rob_id1 = 0; need_rob_id2 = 0;
        idle_inputs();
        at_neg();
        chk("reset_full", full, 0);
        chk("reset_regval", need_set_reg_value, 0);
        chk("reset_clear", clear, 0);
        step(); rst_n = 1;

        // Basic rename and commit
        issue_valid = 1; issue_rd = 5;
        at_neg();
        chk("dep_valid", need_set_reg_dep, 1);
        chk("dep_reg", set_dep_reg_id, 5);
        chk("dep_rob", set_dep_rob_id, 0);
        step(); idle_inputs();
        wb_valid = 1; wb_rob_id = 0; wb_value = 32'h1234;
        push_commit(5, 32'h1234, 0);
        step(); idle_inputs();
        at_neg();
        chk("basic_commit_seen", need_set_reg_value, 1);
        step();

        // Fill to full from a clean state
        rst_n = 0; step(); rst_n = 1;
        for (int i = 0; i < 8; i++) begin
            issue_valid = 1; issue_rd = 5'(i + 1);
            at_neg();
            chk("fill_rob_id", issue_rob_id, 32'(i));
            step();
        end
        issue_valid = 1; issue_rd = 9;
        at_neg();
        chk("full_set", full, 1);
        chk("ninth_rejected", need_set_reg_dep, 0);
        chk("tail_wrapped", issue_rob_id, 0);
        step(); idle_inputs();
        wb_valid = 1; wb_rob_id = 0; wb_value = 32'hA0;
        push_commit(1, 32'hA0, 0);
        step(); idle_inputs();
        issue_valid = 1; issue_rd = 9;
        at_neg();
        chk("full_during_commit", full, 1);
        chk("issue_rejected_on_commit", need_set_reg_dep, 0);
        step();
        issue_rd = 10;
        at_neg();
        chk("full_released", full, 0);
        chk("refill_dep", need_set_reg_dep, 1);
        chk("refill_rob", set_dep_rob_id, 0);
        step(); idle_inputs();

        // Reset with a ready head entry: no commit afterwards
        wb_valid = 1; wb_rob_id = 1; wb_value = 32'hB1;
        step(); idle_inputs();
        rst_n = 0;
        at_neg();
        chk("midreset_full", full, 0);
        chk("midreset_regval", need_set_reg_value, 0);
        step(); step(); rst_n = 1;
        need_rob_id1 = 1;
        at_neg();
        chk("postreset_lookup", rob_value1_ready, 0);
        step();

        // Out-of-order writeback, in-order commit
        issue_valid = 1; issue_rd = 3; step();
        issue_rd = 4; step(); idle_inputs();
        wb_valid = 1; wb_rob_id = 1; wb_value = 32'h11; step();
        wb_rob_id = 0; wb_value = 32'h22;
        push_commit(3, 32'h22, 0);
        push_commit(4, 32'h11, 1);
        step(); idle_inputs();
        at_neg(); chk("ooo_commit0", need_set_reg_value, 1);
        step();
        at_neg(); chk("ooo_commit1", need_set_reg_value, 1);
        step();

        // Mispredicted branch flush
        issue_valid = 1; issue_rd = 0; issue_is_branch = 1; issue_alt_pc = 32'h100;
        at_neg();
        chk("branch_id", issue_rob_id, 2);
        chk("branch_no_dep", need_set_reg_dep, 0);
        step(); idle_inputs();
        issue_valid = 1; issue_rd = 7;
        wb_valid = 1; wb_rob_id = 2; wb_value = 0; wb_mispredict = 1;
        push_clear(32'h100);
        step(); idle_inputs();
        issue_valid = 1; issue_rd = 8;
        wb_valid = 1; wb_rob_id = 3; wb_value = 5;
        at_neg();
        chk("flush_pulse", clear, 1);
        chk("flush_blocks_issue", need_set_reg_dep, 0);
        step(); idle_inputs();
        need_rob_id1 = 2; need_rob_id2 = 3;
        at_neg();
        chk("post_flush_clear", clear, 0);
        chk("post_flush_lookup1", rob_value1_ready, 0);
        chk("post_flush_lookup2", rob_value2_ready, 0);
        chk("post_flush_full", full, 0);
        step();

        // Lookup timing around writeback
        for (int i = 0; i < 4; i++) begin
            issue_valid = 1; issue_rd = 5'(i + 1);
            at_neg();
            chk("lk_rob_id", issue_rob_id, 32'(i));
            step();
        end
        idle_inputs();
        wb_valid = 1; wb_rob_id = 3; wb_value = 32'hBEEF;
        need_rob_id1 = 3; need_rob_id2 = 2;
        at_neg();
        chk("lk_same_ready", rob_value1_ready, 32'(BYP));
        chk("lk_same_value", rob_value1, BYP ? 32'hBEEF : 32'h0);
        chk("lk_other_ready", rob_value2_ready, 0);
        step();
        wb_rob_id = 0; wb_value = 32'h10;
        push_commit(1, 32'h10, 0);
        at_neg();
        chk("lk_next_ready", rob_value1_ready, 1);
        chk("lk_next_value", rob_value1, 32'hBEEF);
        step();
        wb_rob_id = 1; wb_value = 32'h11; push_commit(2, 32'h11, 1); step();
        wb_rob_id = 2; wb_value = 32'h12; push_commit(3, 32'h12, 2);
        push_commit(4, 32'hBEEF, 3); step();
        idle_inputs(); step(); step(); step();

        // Stall with rdy low while a commit is pending
        issue_valid = 1; issue_rd = 9;
        at_neg(); chk("stall_rob_id", issue_rob_id, 4);
        step(); idle_inputs();
        wb_valid = 1; wb_rob_id = 4; wb_value = 32'h77; step(); idle_inputs();
        rdy = 0; issue_valid = 1; issue_rd = 11;
        for (int i = 0; i < 2; i++) begin
            at_neg();
            chk("stall_no_commit", need_set_reg_value, 0);
            chk("stall_no_dep", need_set_reg_dep, 0);
            step();
        end
        idle_inputs(); rdy = 1;
        push_commit(9, 32'h77, 4);
        at_neg(); chk("stall_resume", need_set_reg_value, 1);
        step();

        // rd == 0 commits silently
        issue_valid = 1; issue_rd = 0; step(); idle_inputs();
        wb_valid = 1; wb_rob_id = 5; wb_value = 32'h55; step(); idle_inputs();
        at_neg(); chk("rd0_silent", need_set_reg_value, 0);
        step(); step();

        chk("all_expected_seen", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 Parameter: ROB_IDX_W, default 3, index width; depth = 2**ROB_IDX_W entries (matches `robsize`).
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 rdy  in  1  global enable; low freezes all state.
REQ-005 issue_valid  in  1 / issue_rd  in  5 / issue_is_branch  in  1 / issue_alt_pc  in  32  new instruction: dest reg, branch flag, recovery PC.
REQ-006 full  out  1 / issue_rob_id  out  ROB_IDX_W  cannot accept; id given to the current issue.
REQ-007 wb_valid  in  1 / wb_rob_id  in  ROB_IDX_W / wb_value  in  32 / wb_mispredict  in  1  result writeback.
REQ-008 need_set_reg_dep  out  1 / set_dep_reg_id  out  5 / set_dep_rob_id  out  ROB_IDX_W  rename to register file.
REQ-009 need_set_reg_value  out  1 / set_value_reg_id  out  5 / set_val  out  32 / set_reg_rob_id  out  ROB_IDX_W  commit to register file.
REQ-010 need_rob_id1, need_rob_id2  in  ROB_IDX_W  operand lookups from register file.
REQ-011 rob_value1_ready, rob_value2_ready  out  1 / rob_value1, rob_value2  out  32  lookup responses.
REQ-012 clear  out  1 / redirect_pc  out  32  flush and fetch redirect.

Function
REQ-013 Circular queue: head, tail pointers ROB_IDX_W bits, wrap modulo depth; count ROB_IDX_W+1 bits; entry = busy, ready, rd, value, is_branch, mispredict, alt_pc.
REQ-014 full = (count == depth); issue accepted iff issue_valid & !full & rdy & !clear; accepted issue writes entry at tail (busy=1, ready=0), tail+1.
REQ-015 issue_rob_id = tail, combinational.
REQ-016 need_set_reg_dep = accepted issue & issue_rd != 0, combinational same cycle; set_dep_reg_id = issue_rd, set_dep_rob_id = tail.
REQ-017 wb_valid to a busy entry sets ready=1, value, mispredict at the edge; wb to a non-busy entry ignored.
REQ-018 Commit when count != 0 & head entry ready & rdy: combinational outputs that cycle, head+1 and busy cleared at the edge.
REQ-019 Non-branch commit with rd != 0: need_set_reg_value=1, set_value_reg_id=rd, set_val=value, set_reg_rob_id=head; rd == 0 commits silently.
REQ-020 Branch commit with mispredict=1: clear=1, redirect_pc=alt_pc for that cycle; at the edge all entries busy=0, head=tail=0, count=0; issue and wb that cycle discarded.
REQ-021 Simultaneous issue and commit: count unchanged; full evaluated on pre-edge count (issue into full ROB rejected even if commit frees a slot).
REQ-022 Lookup n: rob_valueN_ready = busy & ready of entry need_rob_idN; rob_valueN = its value; non-busy entry gives ready=0, value 0.
REQ-023 All outputs are 0 whenever the ROB is empty and no issue is present.

Reset
REQ-024 rst_n low asynchronously clears head, tail, count, all busy/ready/mispredict; outputs 0, full=0 while reset asserted.
REQ-025 Reset mid-operation discards all in-flight entries; no commit pulse on release.

Configuration
REQ-026 Macro ROB_WB_BYPASS_EN: defined -> lookup with wb_valid & wb_rob_id == need_rob_idN & entry busy returns ready=1, value=wb_value same cycle; undefined -> result visible from the cycle after writeback only.

Verification
REQ-027 Reset, issue rd=5 -> need_set_reg_dep=1, set_dep_reg_id=5, set_dep_rob_id=0; wb id0 value 0x1234 -> next cycle need_set_reg_value=1, set_val=0x1234, set_reg_rob_id=0.
REQ-028 Issue 8 entries (ROB_IDX_W=3) with no wb -> full=1; 9th issue ignored, tail stays 0; wb id0, commit -> full=0 next cycle.
REQ-029 Out-of-order wb: issue ids 0,1; wb id1 then id0 -> commits id0 then id1 in consecutive cycles.
REQ-030 Branch id2 with alt_pc 0x100, wb mispredict=1 -> at head clear=1, redirect_pc=0x100 one cycle; afterwards count=0, lookups ready=0.
REQ-031 Lookup id3 in wb cycle of value 0xBEEF -> ready=1 same cycle with ROB_WB_BYPASS_EN, next cycle without.
REQ-032 rdy=0 during pending commit -> no outputs asserted, state held; resumes when rdy=1.
